iob2wb_bridge: RTL and testbench

Native-bus responder that sits between the IOb native interface (valid/address/wdata/wstrb → ready/rdata) and the Wishbone classic slave port of the Ethernet MAC register file. Each native request, a single-cycle `valid` pulse, is captured and converted into exactly one Wishbone classic cycle. The result comes back as a single-cycle `ready` pulse carrying `rdata`. A cycle counter guards against slaves that never acknowledge.

---
 rtl/iob2wb_bridge_if.sv | 71 +++++++
 rtl/iob2wb_bridge.sv | 193 +++++++++++++++++++
 tb/tb_iob2wb_bridge.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/iob2wb_bridge_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces for iob2wb_bridge.
//
// iob_if : IOb native bus.
//   valid   request pulse               (master -> slave)
//   address word address, ADDR_W bits   (master -> slave)
//   wdata   write data, DATA_W bits     (master -> slave)
//   wstrb   byte strobes; 0 means read  (master -> slave)
//   rdata   read data, valid with ready (slave -> master)
//   ready   one-cycle response pulse    (slave -> master)
//   error   response ended in bus error or timeout (slave -> master)
//
// wb_if : Wishbone classic bus, signal names seen from the master side.
//   wb_adr_o byte address, ADDR_W+2 bits (master -> slave)
//   wb_dat_o write data                  (master -> slave)
//   wb_sel_o byte selects                (master -> slave)
//   wb_we_o  write enable                (master -> slave)
//   wb_cyc_o cycle valid                 (master -> slave)
//   wb_stb_o strobe                      (master -> slave)
//   wb_dat_i read data                   (slave -> master)
//   wb_ack_i normal termination          (slave -> master)
//   wb_err_i error termination           (slave -> master)
// ---------------------------------------------------------------------------

interface iob_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;
  logic                  error;

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready, error
  );

  modport slave (
    input  valid, address, wdata, wstrb,
    output rdata, ready, error
  );
endinterface

interface wb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W+1:0]     wb_adr_o;
  logic [DATA_W-1:0]     wb_dat_o;
  logic [DATA_W/8-1:0]   wb_sel_o;
  logic                  wb_we_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/iob2wb_bridge.sv
// ---------------------------------------------------------------------------
// iob2wb_bridge
//
// Converts each IOb native request (single-cycle valid pulse) into exactly one
// Wishbone classic cycle and returns the result as a single-cycle ready pulse.
// A wait counter forces termination when the slave never answers.
//
// Ports:
//   clk_i   system clock (only clock)
//   arst_i  asynchronous active-high reset
//   iob     IOb native bus, slave side (valid/address/wdata/wstrb in,
//           rdata/ready/error out)
//   wb      Wishbone classic bus, master side (adr/dat/sel/we/cyc/stb out,
//           dat_i/ack_i/err_i in)
//
// Every output comes straight from a register or from the state register, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------

module iob2wb_bridge #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic  clk_i,
  input logic  arst_i,
  iob_if.slave iob,
  wb_if.master wb
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  // Read data returned when the slave never terminates the cycle.
  localparam logic [DATA_W-1:0] TMO_DATA = {DATA_W/32{32'hDEADBEEF}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  // Control strobes decoded by the FSM, consumed by the datapath.
  logic capture;   // accept a new request
  logic term_ack;  // normal termination
  logic term_err;  // slave error termination
  logic term_tmo;  // forced termination on timeout

  // Latched Wishbone request.
  logic [ADDR_W+1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [STRB_W-1:0] sel_q;
  logic              we_q;

  // Response registers.
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;

  // Wait counter: number of BUS cycles already completed.
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_hit;

  // The cycle is forced to end on the edge at which the counter would reach
  // TIMEOUT, so BUS lasts exactly TIMEOUT cycles when nobody answers.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a missing default
  // on any path would infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    term_ack   = 1'b0;
    term_err   = 1'b0;
    term_tmo   = 1'b0;

    unique case (state)
      IDLE: begin
        if (iob.valid) begin
          capture    = 1'b1;
          state_next = BUS;
        end
      end

      BUS: begin
        // Error wins over a simultaneous ack; timeout only when both are low.
        if (wb.wb_err_i) begin
          term_err = 1'b1;
        end else if (wb.wb_ack_i) begin
          term_ack = 1'b1;
        end else if (timeout_hit) begin
          term_tmo = 1'b1;
        end

        if (wb.wb_err_i || wb.wb_ack_i || timeout_hit) begin
          state_next = RESP;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latch and wait counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (capture) begin
        adr_q <= {iob.address, 2'b00};
        dat_q <= iob.wdata;
        we_q  <= |iob.wstrb;
        // Reads select every byte lane; writes pass the strobes through.
        sel_q <= (|iob.wstrb) ? iob.wstrb : {STRB_W{1'b1}};
        cnt_q <= '0;
      end else if (state == BUS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (term_err) begin
        rdata_q <= '0;
        error_q <= 1'b1;
      end else if (term_ack) begin
        rdata_q <= we_q ? '0 : wb.wb_dat_i;
        error_q <= 1'b0;
      end else if (term_tmo) begin
        rdata_q <= TMO_DATA;
        error_q <= 1'b1;
      end else if (state == RESP) begin
        // Response is only meaningful during the ready cycle.
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // cyc/stb decode straight from the state register: they rise on the edge
  // that accepts valid, fall on the edge that enters RESP (the same edge that
  // raises ready), and drop immediately on reset.
  assign wb.wb_cyc_o = (state == BUS);
  assign wb.wb_stb_o = (state == BUS);
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;

  assign iob.ready   = (state == RESP);
  assign iob.rdata   = rdata_q;
  assign iob.error   = error_q;

endmodule

// File: tb/tb_iob2wb_bridge.sv
// ---------------------------------------------------------------------------
// Directed testbench for iob2wb_bridge (TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------

module tb_iob2wb_bridge;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic clk_i;
  logic arst_i;

  iob_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) iob ();
  wb_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

  iob2wb_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .iob   (iob),
    .wb    (wb)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;

  // Wishbone request as seen in the first BUS cycle of the last transaction.
  logic [ADDR_W+1:0] snap_adr;
  logic [DATA_W-1:0] snap_dat;
  logic [3:0]        snap_sel;
  logic              snap_we;

  // Results of the last transaction.
  int          lat;
  int          cyc_cnt;
  logic [31:0] rd;
  logic        er;
  int          extra_ready;
  int          extra_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issue one request and play the slave. ack_delay < 0 means the slave
  // never answers. stray_at > 0 sends an extra valid pulse (address 0x7FF,
  // read) at that falling edge. lat = falling edge index (1 = first one after
  // the edge that samples valid) at which ready is seen, 0 if never.
  task automatic run_txn(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int ack_delay, input bit with_err, input logic [31:0] sd,
                         input int stray_at);
    @(negedge clk_i);
    iob.valid   = 1'b1;
    iob.address = a;
    iob.wdata   = d;
    iob.wstrb   = s;
    lat     = 0;
    cyc_cnt = 0;
    rd      = 'x;
    er      = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      iob.valid   = (i == stray_at);
      if (i == stray_at) begin
        iob.address = 12'h7FF;
        iob.wstrb   = 4'h0;
      end
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
      wb.wb_dat_i = '0;
      if (iob.ready) begin
        lat = i;
        rd  = iob.rdata;
        er  = iob.error;
        break;
      end
      if (wb.wb_cyc_o) cyc_cnt++;
      if (i == 1) begin
        snap_adr = wb.wb_adr_o;
        snap_dat = wb.wb_dat_o;
        snap_sel = wb.wb_sel_o;
        snap_we  = wb.wb_we_o;
      end
      if (wb.wb_cyc_o && ack_delay >= 0 && i == 1 + ack_delay) begin
        wb.wb_ack_i = 1'b1;
        wb.wb_err_i = with_err;
        wb.wb_dat_i = sd;
      end
    end
    iob.valid = 1'b0;
  endtask

  // Watch n falling edges for unexpected activity.
  task automatic watch_idle(input int n);
    extra_ready = 0;
    extra_cyc   = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (iob.ready)   extra_ready++;
      if (wb.wb_cyc_o) extra_cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_i      = 1'b1;
    iob.valid   = 1'b0;
    iob.address = '0;
    iob.wdata   = '0;
    iob.wstrb   = '0;
    wb.wb_dat_i = '0;
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;

    // Reset state.
    #1;
    check("rst_ready", iob.ready, 0);
    check("rst_cyc",   wb.wb_cyc_o, 0);
    check("rst_stb",   wb.wb_stb_o, 0);
    check("rst_rdata", iob.rdata, 0);
    check("rst_adr",   wb.wb_adr_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    arst_i = 1'b0;

    // 1. Full write, slave acks one cycle after stb.
    run_txn(12'h000, 32'h0000A080, 4'hF, 1, 1'b0, 32'h0, 0);
    check("wr_adr",   snap_adr, 14'h0000);
    check("wr_we",    snap_we, 1);
    check("wr_sel",   snap_sel, 4'hF);
    check("wr_dat",   snap_dat, 32'h0000A080);
    check("wr_lat",   lat, 3);
    check("wr_rdata", rd, 0);
    check("wr_error", er, 0);
    @(negedge clk_i);
    check("wr_ready_single", iob.ready, 0);
    check("wr_rdata_clear",  iob.rdata, 0);

    // 2. Read with immediate ack.
    run_txn(12'h001, 32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h12345678, 0);
    check("rd_adr",   snap_adr, 14'h0004);
    check("rd_sel",   snap_sel, 4'hF);
    check("rd_we",    snap_we, 0);
    check("rd_lat",   lat, 2);
    check("rd_rdata", rd, 32'h12345678);
    check("rd_error", er, 0);
    @(negedge clk_i);
    check("rd_rdata_clear", iob.rdata, 0);

    // 3. Partial write, stray valid while BUS is waiting.
    run_txn(12'h002, 32'h55AA1234, 4'h3, 2, 1'b0, 32'h0, 2);
    check("pw_sel", snap_sel, 4'h3);
    check("pw_adr", snap_adr, 14'h0008);
    check("pw_lat", lat, 4);
    watch_idle(6);
    check("pw_extra_ready", extra_ready, 0);
    check("pw_extra_cyc",   extra_cyc, 0);
    check("pw_adr_hold",    wb.wb_adr_o, 14'h0008);

    // 4. Error together with ack on a read.
    run_txn(12'h003, 32'h0, 4'h0, 0, 1'b1, 32'hCAFEF00D, 0);
    check("err_lat",   lat, 2);
    check("err_error", er, 1);
    check("err_rdata", rd, 0);

    // 5. Timeout: slave never answers.
    run_txn(12'h010, 32'h0, 4'h0, -1, 1'b0, 32'h0, 0);
    check("tmo_cyc_cycles", cyc_cnt, 4);
    check("tmo_lat",        lat, 5);
    check("tmo_error",      er, 1);
    check("tmo_rdata",      rd, 32'hDEADBEEF);
    @(negedge clk_i);
    check("tmo_error_clear", iob.error, 0);
    run_txn(12'h011, 32'h0, 4'h0, 0, 1'b0, 32'h0BADF00D, 0);
    check("post_tmo_lat",   lat, 2);
    check("post_tmo_rdata", rd, 32'h0BADF00D);
    check("post_tmo_error", er, 0);

    // 6. Reset in the middle of a BUS cycle.
    @(negedge clk_i);
    iob.valid   = 1'b1;
    iob.address = 12'h0AB;
    iob.wdata   = 32'h0;
    iob.wstrb   = 4'h0;
    @(negedge clk_i);
    iob.valid = 1'b0;
    check("mid_cyc_before", wb.wb_cyc_o, 1);
    #2;
    arst_i = 1'b1;
    #1;
    check("mid_cyc_rst",   wb.wb_cyc_o, 0);
    check("mid_stb_rst",   wb.wb_stb_o, 0);
    check("mid_ready_rst", iob.ready, 0);
    check("mid_adr_rst",   wb.wb_adr_o, 0);
    @(negedge clk_i);
    arst_i = 1'b0;
    watch_idle(5);
    check("mid_extra_ready", extra_ready, 0);
    check("mid_extra_cyc",   extra_cyc, 0);

    // Back-to-back write then read.
    run_txn(12'h020, 32'h11223344, 4'hF, 0, 1'b0, 32'h0, 0);
    check("b2b_wr_adr", snap_adr, 14'h0080);
    check("b2b_wr_we",  snap_we, 1);
    check("b2b_wr_lat", lat, 2);
    check("b2b_wr_err", er, 0);
    run_txn(12'h021, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5A5A5, 0);
    check("b2b_rd_adr",   snap_adr, 14'h0084);
    check("b2b_rd_lat",   lat, 3);
    check("b2b_rd_rdata", rd, 32'hA5A5A5A5);
    check("b2b_rd_err",   er, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
